rom_fetch_arbiter: RTL and testbench
====================================

# rom_fetch_arbiter

Shares one 16-bit SDRAM read port between the three byte-wide ROM fetchers of the System 1 core: main CPU, sound CPU and sprite engine. Each requester gets a one-word line buffer. Misses are serialised onto the SDRAM controller's toggle req/ack port, with the correct region base added to each address. The block sits between `SEGASYSTEM1` and the `sdram` controller and replaces three dedicated SDRAM read channels.

## Interface

Parameters:
- `BASE0`, default 23'h04000: word base of the main CPU region.
- `BASE1`, default 23'h00000: word base of the sound CPU region.
- `BASE2`, default 23'h10000: word base of the sprite region.

Ports:
- `clk_sys`  in  1  system clock (40 MHz); the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `download`  in  1  ROM download in progress (`ioctl_downl`).
- `rq0_addr`  in  17  main CPU byte address.
- `rq1_addr`  in  17  sound CPU byte address; bits 16:15 are tied 0.
- `rq2_addr`  in  17  sprite byte address.
- `rqN_valid`  in  1  (N=0..2) requester N wants data at `rqN_addr`.
- `rqN_dout`  out  8  byte at `rqN_addr`; valid while `rqN_ready`=1.
- `rqN_ready`  out  1  line buffer N holds the word for the current `rqN_addr`.
- `mem_req`  out  1  toggle request to the SDRAM port.
- `mem_ack`  in  1  toggle acknowledge; equals `mem_req` when the read is done.
- `mem_addr`  out  23  SDRAM word address.
- `mem_q`  in  16  SDRAM read data; valid when `mem_ack`==`mem_req`.
- `busy`  out  1  a transaction is outstanding (state ≠ IDLE).

## Operation

- Each requester has a line buffer: `tagN[15:0]`, `dataN[15:0]`, `vN`.
- Hit: `vN` & (`tagN` == `rqN_addr[16:1]`).
  - `rqN_ready` = hit. It is combinational from the registers.
  - `rqN_dout` = `rqN_addr[0]` ? `dataN[15:8]` : `dataN[7:0]`.
- Pending: `rqN_valid` & !hit & !`download`.
- State machine with two states: IDLE and WAIT.
- IDLE, with any requester pending:
  - Select the winner by round-robin, starting at `rr_ptr`.
  - Latch `gnt` and `gtag` = `rq_addr[16:1]`.
  - Drive `mem_addr` = `BASEgnt` + {7'b0, `gtag`}. Wrap modulo 2^23.
  - Toggle `mem_req` and go to WAIT.
  - Set `rr_ptr` to (`gnt`+1) mod 3.
- WAIT, when `mem_ack`==`mem_req`:
  - If `download` is low, write `tag[gnt]`←`gtag`, `data[gnt]`←`mem_q`, `v[gnt]`←1.
  - Return to IDLE.
- Requester address changes during WAIT: the fill still uses `gtag`. The requester misses again and is re-queued.
- `download` high:
  - All `vN` are cleared every cycle.
  - No new issue is made.
  - An outstanding WAIT completes its handshake but discards the data.
- An idle requester (`rqN_valid`=0) never issues. Its `rqN_ready` still reflects the current hit status.
- `mem_addr` holds its value after the transaction and changes only at the next issue.

## Timing

- Reset values:
  - `mem_req`=0, `mem_addr`=0, state IDLE, `busy`=0.
  - `rr_ptr`=0, all `vN`=0, `tagN`=0, `dataN`=0.
  - Therefore `rqN_ready`=0 and `rqN_dout`=0.
- Miss latency:
  - The miss appears in cycle t. `mem_req` toggles at the t/t+1 edge.
  - `mem_ack` matches in cycle k. The fill happens at the k/k+1 edge.
  - `rqN_ready`=1 from cycle k+1.
  - Next issue no earlier than cycle k+1.
- At most one outstanding transaction. `mem_req` never toggles in WAIT.
- Hit latency is 0 cycles: an address change onto a buffered word shows `ready` in the same cycle.
- Simultaneous misses on all three, with `rr_ptr`=0: issue order 0, 1, 2.
- `reset_n` asserted mid-WAIT:
  - Everything returns to reset values immediately.
  - The SDRAM side may see `mem_req` drop while a request is in flight. The controller is reset by the same `reset_n` source.

## Configuration

- `ROMARB_FIXED_PRIO_EN`:
  - Defined: fixed priority sprite (2) > main (0) > sound (1). `rr_ptr` is removed.
  - Undefined: round-robin as in Operation.
- All other behaviour is identical in both builds.

## Test plan

1. Reset, then `rq0_valid`=1, `rq0_addr`=17'h00003. Model acks 4 cycles after the toggle with `mem_q`=16'hA55A. Required: `mem_addr`=23'h04001, one `mem_req` toggle, `rq0_ready` rises 5 cycles after the toggle, `rq0_dout`=8'hA5.
2. After test 1, `rq0_addr`=17'h00002. Required: same-cycle `rq0_ready`=1, `rq0_dout`=8'h5A, no `mem_req` toggle.
3. All three miss together: `rq1_addr`=17'h00010, `rq2_addr`=17'h00020. Required: `mem_addr` sequence 23'h04xxx, 23'h00008, 23'h10010. With `ROMARB_FIXED_PRIO_EN` the order is 2, 0, 1.
4. Change `rq2_addr` during WAIT. Required: the fill uses the old tag, `rq2_ready` stays 0, and a second request issues for the new address.
5. Assert `download` during WAIT, then ack. Required: no `vN` set, all `rqN_ready`=0, no issue until `download` falls.
6. Pulse `reset_n` low mid-WAIT. Required: `mem_req`=0, `busy`=0 and all `ready`=0 immediately, before any clock edge.

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: three byte-wide ROM fetchers with one-word line buffers share a single
// 16-bit SDRAM toggle req/ack read port. Define ROMARB_FIXED_PRIO_EN for fixed priority 2>0>1.
// Ports: clk_sys, reset_n (async low), download, rqN_addr/valid in, rqN_dout/ready out,
//        mem_req/mem_addr out, mem_ack/mem_q in, busy out.
module rom_fetch_arbiter #(
  parameter logic [22:0] BASE0 = 23'h04000,
  parameter logic [22:0] BASE1 = 23'h00000,
  parameter logic [22:0] BASE2 = 23'h10000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        download,
  input  logic [16:0] rq0_addr,
  input  logic [16:0] rq1_addr,
  input  logic [16:0] rq2_addr,
  input  logic        rq0_valid,
  input  logic        rq1_valid,
  input  logic        rq2_valid,
  output logic [7:0]  rq0_dout,
  output logic [7:0]  rq1_dout,
  output logic [7:0]  rq2_dout,
  output logic        rq0_ready,
  output logic        rq1_ready,
  output logic        rq2_ready,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [22:0] mem_addr,
  input  logic [15:0] mem_q,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [15:0]       gtag_q, gtag_d;
  logic              mem_req_q, mem_req_d;
  logic [22:0]       mem_addr_q, mem_addr_d;
  logic [2:0][15:0]  tag_q, tag_d;
  logic [2:0][15:0]  data_q, data_d;
  logic [2:0]        v_q, v_d;

  logic [2:0][16:0]  rq_addr;
  logic [2:0]        rq_valid;
  logic [2:0]        hit;
  logic [2:0]        pend;
  logic [1:0]        sel;
  logic              found;
  logic [22:0]       base_sel;
  logic [15:0]       gtag_sel;

  assign rq_addr  = {rq2_addr, rq1_addr, rq0_addr};
  assign rq_valid = {rq2_valid, rq1_valid, rq0_valid};

  always_comb begin
    hit  = '0;
    pend = '0;
    for (int n = 0; n < 3; n++) begin
      hit[n]  = v_q[n] & (tag_q[n] == rq_addr[n][16:1]);
      pend[n] = rq_valid[n] & ~hit[n] & ~download;
    end
  end

  assign rq0_ready = hit[0];
  assign rq1_ready = hit[1];
  assign rq2_ready = hit[2];

  assign rq0_dout = rq0_addr[0] ? data_q[0][15:8] : data_q[0][7:0];
  assign rq1_dout = rq1_addr[0] ? data_q[1][15:8] : data_q[1][7:0];
  assign rq2_dout = rq2_addr[0] ? data_q[2][15:8] : data_q[2][7:0];

`ifdef ROMARB_FIXED_PRIO_EN
  always_comb begin
    sel   = 2'd0;
    found = |pend;
    priority case (1'b1)
      pend[2]: sel = 2'd2;
      pend[0]: sel = 2'd0;
      pend[1]: sel = 2'd1;
      default: sel = 2'd0;
    endcase
  end
`else
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] rr_idx;

  // Scan rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first pending wins.
  always_comb begin
    sel    = 2'd0;
    found  = 1'b0;
    rr_idx = 3'd0;
    for (int i = 0; i < 3; i++) begin
      rr_idx = {1'b0, rr_ptr_q} + 3'(i);
      if (rr_idx >= 3'd3) rr_idx = rr_idx - 3'd3;
      if (!found && pend[rr_idx[1:0]]) begin
        found = 1'b1;
        sel   = rr_idx[1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_IDLE && found)
      rr_ptr_d = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= 2'd0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    unique case (sel)
      2'd1:    base_sel = BASE1;
      2'd2:    base_sel = BASE2;
      default: base_sel = BASE0;
    endcase
    gtag_sel = rq_addr[sel][16:1];
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gtag_d     = gtag_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    tag_d      = tag_q;
    data_d     = data_q;
    v_d        = v_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d      = sel;
          gtag_d     = gtag_sel;
          mem_addr_d = base_sel + {7'b0, gtag_sel};
          mem_req_d  = ~mem_req_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack == mem_req_q) begin
          // Fill with the latched tag, not the live address.
          if (!download) begin
            tag_d[gnt_q]  = gtag_q;
            data_d[gnt_q] = mem_q;
            v_d[gnt_q]    = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
    endcase
    if (download) v_d = '0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'd0;
      gtag_q     <= 16'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 23'd0;
      tag_q      <= '0;
      data_q     <= '0;
      v_q        <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gtag_q     <= gtag_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      v_q        <= v_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb_rom_fetch_arbiter: directed bench for rom_fetch_arbiter with an SDRAM
// toggle-handshake responder that acks on the fifth falling edge after a request.
module tb_rom_fetch_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        download = 1'b0;
  logic [16:0] rq0_addr = '0;
  logic [16:0] rq1_addr = '0;
  logic [16:0] rq2_addr = '0;
  logic        rq0_valid = 1'b0;
  logic        rq1_valid = 1'b0;
  logic        rq2_valid = 1'b0;
  logic [7:0]  rq0_dout, rq1_dout, rq2_dout;
  logic        rq0_ready, rq1_ready, rq2_ready;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [22:0] mem_addr;
  logic [15:0] mem_q = '0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int toggles = 0;
  int cnt = 0;
  logic prev_req = 1'b0;
  logic [22:0] exp3 [3];

  rom_fetch_arbiter dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .download  (download),
    .rq0_addr  (rq0_addr),
    .rq1_addr  (rq1_addr),
    .rq2_addr  (rq2_addr),
    .rq0_valid (rq0_valid),
    .rq1_valid (rq1_valid),
    .rq2_valid (rq2_valid),
    .rq0_dout  (rq0_dout),
    .rq1_dout  (rq1_dout),
    .rq2_dout  (rq2_dout),
    .rq0_ready (rq0_ready),
    .rq1_ready (rq1_ready),
    .rq2_ready (rq2_ready),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_q     (mem_q),
    .busy      (busy)
  );

  always #12 clk_sys = ~clk_sys;

  function automatic logic [15:0] mem_word(input logic [22:0] a);
    if (a == 23'h04001) return 16'hA55A;
    return a[15:0] ^ 16'h1234;
  endfunction

  always @(negedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_ack  = 1'b0;
      cnt      = 0;
      prev_req = 1'b0;
    end else begin
      if (mem_req !== prev_req) toggles++;
      prev_req = mem_req;
      if (mem_req !== mem_ack) begin
        cnt++;
        if (cnt >= 5) begin
          mem_q   = mem_word(mem_addr);
          mem_ack = mem_req;
          cnt     = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_issue(input string tag);
    int base;
    int n;
    base = toggles;
    n = 0;
    while (toggles == base && n < 60) begin
      tick();
      n++;
    end
    checks++;
    assert (toggles != base) else begin
      errors++;
      $error("FAIL %s observed=timeout expected=issue", tag);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    assert (busy === 1'b0) else begin
      errors++;
      $error("FAIL %s observed=timeout expected=idle", tag);
    end
  endtask

  initial begin
    int base;
`ifdef ROMARB_FIXED_PRIO_EN
    exp3[0] = 23'h10010;
    exp3[1] = 23'h04080;
    exp3[2] = 23'h00008;
`else
    exp3[0] = 23'h04080;
    exp3[1] = 23'h00008;
    exp3[2] = 23'h10010;
`endif

    // Reset state
    tick();
    tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 23'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready0", rq0_ready, 1'b0);
    chk("rst_ready1", rq1_ready, 1'b0);
    chk("rst_ready2", rq2_ready, 1'b0);
    chk("rst_dout0", rq0_dout, 8'h00);
    reset_n = 1'b1;
    tick();

    // Test 1: single miss on requester 0
    rq0_addr  = 17'h00003;
    rq0_valid = 1'b1;
    tick();
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 23'h04001);
    chk("t1_busy", busy, 1'b1);
    chk("t1_toggles", toggles, 1);
    repeat (4) tick();
    chk("t1_ready_early", rq0_ready, 1'b0);
    tick();
    chk("t1_ready", rq0_ready, 1'b1);
    chk("t1_dout", rq0_dout, 8'hA5);
    chk("t1_busy_done", busy, 1'b0);
    repeat (3) tick();
    chk("t1_one_toggle", toggles, 1);

    // Test 2: hit on other byte of the buffered word
    rq0_addr = 17'h00002;
    #1;
    chk("t2_ready", rq0_ready, 1'b1);
    chk("t2_dout", rq0_dout, 8'h5A);
    repeat (3) tick();
    chk("t2_no_toggle", toggles, 1);

    // Test 3: three simultaneous misses from reset
    rq0_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    rq0_addr = 17'h00100;
    rq1_addr = 17'h00010;
    rq2_addr = 17'h00020;
    rq0_valid = 1'b1;
    rq1_valid = 1'b1;
    rq2_valid = 1'b1;
    wait_issue("t3_issue_a");
    chk("t3_addr_a", mem_addr, exp3[0]);
    wait_idle("t3_idle_a");
    wait_issue("t3_issue_b");
    chk("t3_addr_b", mem_addr, exp3[1]);
    wait_idle("t3_idle_b");
    wait_issue("t3_issue_c");
    chk("t3_addr_c", mem_addr, exp3[2]);
    wait_idle("t3_idle_c");
    chk("t3_ready0", rq0_ready, 1'b1);
    chk("t3_ready1", rq1_ready, 1'b1);
    chk("t3_ready2", rq2_ready, 1'b1);
    chk("t3_dout0", rq0_dout, 8'hB4);
    chk("t3_dout1", rq1_dout, 8'h3C);
    chk("t3_dout2", rq2_dout, 8'h24);

    // Test 4: requester 2 moves while its miss is in flight
    rq2_addr = 17'h00040;
    wait_issue("t4_issue_old");
    chk("t4_addr_old", mem_addr, 23'h10020);
    tick();
    rq2_addr = 17'h00060;
    wait_idle("t4_idle_old");
    chk("t4_ready_new_miss", rq2_ready, 1'b0);
    rq2_addr = 17'h00041;
    #1;
    chk("t4_old_tag_hit", rq2_ready, 1'b1);
    chk("t4_old_tag_dout", rq2_dout, 8'h12);
    rq2_addr = 17'h00060;
    wait_issue("t4_issue_new");
    chk("t4_addr_new", mem_addr, 23'h10030);
    wait_idle("t4_idle_new");
    chk("t4_ready_new", rq2_ready, 1'b1);
    chk("t4_dout_new", rq2_dout, 8'h04);
    chk("t4_ready0_kept", rq0_ready, 1'b1);

    // Test 5: download during an outstanding read
    rq1_addr = 17'h00020;
    wait_issue("t5_issue");
    chk("t5_addr", mem_addr, 23'h00010);
    download = 1'b1;
    tick();
    chk("t5_ready0", rq0_ready, 1'b0);
    chk("t5_ready1", rq1_ready, 1'b0);
    chk("t5_ready2", rq2_ready, 1'b0);
    wait_idle("t5_idle");
    base = toggles;
    repeat (8) tick();
    chk("t5_no_issue", toggles, base);
    chk("t5_busy", busy, 1'b0);
    chk("t5_ready1_discard", rq1_ready, 1'b0);
    download = 1'b0;
    wait_issue("t5_issue_after");
    chk("t5_addr_after", mem_addr, 23'h10030);

    // Test 6: reset mid-WAIT acts immediately
    chk("t6_busy_before", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_mem_addr", mem_addr, 23'h0);
    chk("t6_ready0", rq0_ready, 1'b0);
    chk("t6_ready1", rq1_ready, 1'b0);
    chk("t6_ready2", rq2_ready, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
